conv_wb_frontend: RTL and testbench

Wishbone slave front-end that sits directly upstream of the convolution core. It owns the bus side of the accelerator:
- decodes wbs_adr_i[23:16];
- buffers input pixels in an input FIFO and holds 3x3 kernel weights in registers;
- issues start to the core and collects core results in an output FIFO for bus readback.

It replaces ad-hoc bus handling in the core and gives it clean valid/ready streams.

---
 rtl/conv_pkg.sv | 33 +++
 rtl/sync_fifo.sv | 58 +++++
 rtl/conv_wb_frontend.sv | 188 ++++++++++++++++++
 tb/tb_conv_wb_frontend.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants for the convolution accelerator's Wishbone front-end:
// address map, CTRL/STATUS bit positions, default kernel geometry.
package conv_pkg;

   localparam int unsigned DEF_WT_N = 9;
   localparam int unsigned DEF_WT_W = 8;

   localparam logic [7:0] ADDR_CTRL     = 8'h00;
   localparam logic [7:0] ADDR_STATUS   = 8'h01;
   localparam logic [7:0] ADDR_DATA_IN  = 8'h02;
   localparam logic [7:0] ADDR_DATA_OUT = 8'h03;
   localparam logic [7:0] ADDR_WT_BASE  = 8'h10;

   localparam int unsigned CTRL_START     = 0;
   localparam int unsigned CTRL_CLR_FIFO  = 1;
   localparam int unsigned CTRL_CLR_FLAGS = 2;

   localparam int unsigned STAT_BUSY      = 0;
   localparam int unsigned STAT_IN_FULL   = 1;
   localparam int unsigned STAT_IN_EMPTY  = 2;
   localparam int unsigned STAT_OUT_FULL  = 3;
   localparam int unsigned STAT_OUT_EMPTY = 4;
   localparam int unsigned STAT_OVERFLOW  = 5;
   localparam int unsigned STAT_UNDERFLOW = 6;
   localparam int unsigned STAT_IN_CNT    = 8;
   localparam int unsigned STAT_OUT_CNT   = 16;

   typedef enum logic {
      RUN_IDLE = 1'b0,
      RUN_BUSY = 1'b1
   } run_state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO with a one-cycle clear.
// A push on full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             push_ok_c;
   logic             pop_ok_c;

   assign pop_ok_c  = pop & ~empty;
   assign push_ok_c = push & (~full | pop_ok_c);

   // Clear overrides any same-cycle push or pop; storage contents are left as-is.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok_c) begin
            mem_q[wr_ptr_q] <= din;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop_ok_c) rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(push_ok_c) - CW'(pop_ok_c);
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

endmodule

// File: rtl/conv_wb_frontend.sv
// Wishbone slave front-end for the convolution core: register decode, pixel
// input FIFO, result output FIFO, kernel weights and start/busy handshake.
module conv_wb_frontend
   import conv_pkg::*;
#(
   parameter int unsigned DW        = 32,
   parameter int unsigned IN_DEPTH  = 16,
   parameter int unsigned OUT_DEPTH = 16,
   parameter int unsigned WT_N      = DEF_WT_N,
   parameter int unsigned WT_W      = DEF_WT_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [7:0]             addr,
   input  logic [DW-1:0]          data_in,
   input  logic                   we,
   input  logic                   str,
   input  logic                   cyc,
   output logic                   ack,
   output logic [DW-1:0]          data_out,
   output logic                   core_start,
   input  logic                   core_done,
   output logic                   px_valid,
   output logic [DW-1:0]          px_data,
   input  logic                   px_ready,
   output logic [WT_N*WT_W-1:0]   wt_flat,
   input  logic                   res_valid,
   input  logic [DW-1:0]          res_data,
   output logic                   res_ready,
   output logic                   busy
);

   localparam int unsigned IN_CW  = $clog2(IN_DEPTH) + 1;
   localparam int unsigned OUT_CW = $clog2(OUT_DEPTH) + 1;

   logic              req_c, wr_c, rd_c;
   logic              sel_ctrl_c, sel_status_c, sel_din_c, sel_dout_c;
   logic              fifo_clr_c, flags_clr_c, start_req_c;
   logic              in_push_c, in_pop_c, in_full, in_empty;
   logic              out_push_c, out_pop_c, out_full, out_empty;
   logic [IN_CW-1:0]  in_count;
   logic [OUT_CW-1:0] out_count;
   logic [DW-1:0]     out_head;
   logic              overflow_q, underflow_q;
   logic [WT_W-1:0]   wt_q [WT_N];
   run_state_t        state_q, state_d;
   logic              start_d;
   logic [DW-1:0]     status_c, rdata_c;

   // A request is only taken while ack is low, so acks can never be back-to-back.
   assign req_c = str & cyc & ~ack;
   assign wr_c  = req_c & we;
   assign rd_c  = req_c & ~we;

   assign sel_ctrl_c   = (addr == ADDR_CTRL);
   assign sel_status_c = (addr == ADDR_STATUS);
   assign sel_din_c    = (addr == ADDR_DATA_IN);
   assign sel_dout_c   = (addr == ADDR_DATA_OUT);

   assign fifo_clr_c  = wr_c & sel_ctrl_c & data_in[CTRL_CLR_FIFO];
   assign flags_clr_c = wr_c & sel_ctrl_c & data_in[CTRL_CLR_FLAGS];
   assign start_req_c = wr_c & sel_ctrl_c & data_in[CTRL_START];

   assign in_push_c  = wr_c & sel_din_c;
   assign in_pop_c   = px_valid & px_ready;
   assign out_push_c = res_valid & res_ready;
   assign out_pop_c  = rd_c & sel_dout_c;

   sync_fifo #(.WIDTH(DW), .DEPTH(IN_DEPTH)) u_in_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (fifo_clr_c),
      .push  (in_push_c),
      .pop   (in_pop_c),
      .din   (data_in),
      .dout  (px_data),
      .full  (in_full),
      .empty (in_empty),
      .count (in_count)
   );

   sync_fifo #(.WIDTH(DW), .DEPTH(OUT_DEPTH)) u_out_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (fifo_clr_c),
      .push  (out_push_c),
      .pop   (out_pop_c),
      .din   (res_data),
      .dout  (out_head),
      .full  (out_full),
      .empty (out_empty),
      .count (out_count)
   );

   assign px_valid  = ~in_empty;
   assign res_ready = ~out_full;

   // Sticky error flags; only a CTRL write can clear them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (flags_clr_c) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (in_push_c & in_full & ~in_pop_c) overflow_q  <= 1'b1;
         if (out_pop_c & out_empty)           underflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(WT_N); i++) wt_q[i] <= '0;
      end else begin
         for (int i = 0; i < int'(WT_N); i++) begin
            if (wr_c && (addr == ADDR_WT_BASE + 8'(i))) wt_q[i] <= data_in[WT_W-1:0];
         end
      end
   end

   for (genvar g = 0; g < int'(WT_N); g++) begin : g_wt_flat
      assign wt_flat[g*WT_W +: WT_W] = wt_q[g];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN_IDLE;
         core_start <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_d;
         core_start <= start_d;
         busy       <= (state_d == RUN_BUSY);
      end
   end

   // Done takes priority: a start landing in the same cycle as done is dropped.
   always_comb begin
      state_d = state_q;
      start_d = 1'b0;
      case (state_q)
         RUN_IDLE: begin
            if (start_req_c && !core_done) begin
               state_d = RUN_BUSY;
               start_d = 1'b1;
            end
         end
         RUN_BUSY: begin
            if (core_done) state_d = RUN_IDLE;
         end
         default: state_d = RUN_IDLE;
      endcase
   end

   always_comb begin
      status_c                          = '0;
      status_c[STAT_BUSY]               = busy;
      status_c[STAT_IN_FULL]            = in_full;
      status_c[STAT_IN_EMPTY]           = in_empty;
      status_c[STAT_OUT_FULL]           = out_full;
      status_c[STAT_OUT_EMPTY]          = out_empty;
      status_c[STAT_OVERFLOW]           = overflow_q;
      status_c[STAT_UNDERFLOW]          = underflow_q;
      status_c[STAT_IN_CNT +: IN_CW]    = in_count;
      status_c[STAT_OUT_CNT +: OUT_CW]  = out_count;
   end

   always_comb begin
      rdata_c = '0;
      if (sel_status_c)             rdata_c = status_c;
      if (sel_dout_c && !out_empty) rdata_c = out_head;
      for (int i = 0; i < int'(WT_N); i++) begin
         if (addr == ADDR_WT_BASE + 8'(i)) rdata_c = DW'(wt_q[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack      <= 1'b0;
         data_out <= '0;
      end else begin
         ack      <= req_c;
         data_out <= rd_c ? rdata_c : '0;
      end
   end

endmodule

// File: tb/tb_conv_wb_frontend.sv
// Self-checking bench for conv_wb_frontend: directed scenarios followed by a
// randomized mix of bus and core-side operations checked against a queue model.
module tb_conv_wb_frontend;
   import conv_pkg::*;

   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned WN    = 9;
   localparam int unsigned WW    = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [7:0]        addr = '0;
   logic [DW-1:0]     data_in = '0;
   logic              we = 1'b0, str = 1'b0, cyc = 1'b0;
   logic              ack;
   logic [DW-1:0]     data_out;
   logic              core_start;
   logic              core_done = 1'b0;
   logic              px_valid;
   logic [DW-1:0]     px_data;
   logic              px_ready = 1'b0;
   logic [WN*WW-1:0]  wt_flat;
   logic              res_valid = 1'b0;
   logic [DW-1:0]     res_data = '0;
   logic              res_ready;
   logic              busy;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model state
   logic [31:0] in_q[$];
   logic [31:0] out_q[$];
   logic        ovf_m = 1'b0, udf_m = 1'b0, busy_m = 1'b0;
   logic [7:0]  wt_m [WN];

   always #5 clk = ~clk;

   conv_wb_frontend dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in), .we(we),
      .str(str), .cyc(cyc), .ack(ack), .data_out(data_out),
      .core_start(core_start), .core_done(core_done),
      .px_valid(px_valid), .px_data(px_data), .px_ready(px_ready),
      .wt_flat(wt_flat), .res_valid(res_valid), .res_data(res_data),
      .res_ready(res_ready), .busy(busy)
   );

   // One bus access; returns read data, ack count and core_start pulses seen.
   task automatic wb_xfer(input logic [7:0] a, input logic w, input logic [31:0] d,
                          output logic [31:0] rd, output int acks, output int starts);
      addr = a; we = w; data_in = d; str = 1'b1; cyc = 1'b1;
      rd = '0; acks = 0; starts = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (core_start) starts++;
         if (ack) begin
            acks++;
            rd = data_out;
            str = 1'b0; cyc = 1'b0;
         end
      end
      str = 1'b0; cyc = 1'b0; we = 1'b0;
   endtask

   function automatic logic [31:0] exp_status();
      logic [31:0] s;
      s = '0;
      s[0] = busy_m;
      s[1] = (in_q.size() == DEPTH);
      s[2] = (in_q.size() == 0);
      s[3] = (out_q.size() == DEPTH);
      s[4] = (out_q.size() == 0);
      s[5] = ovf_m;
      s[6] = udf_m;
      s[12:8]  = 5'(in_q.size());
      s[20:16] = 5'(out_q.size());
      return s;
   endfunction

   function automatic logic [71:0] exp_wt();
      logic [71:0] v;
      for (int i = 0; i < int'(WN); i++) v[i*8 +: 8] = wt_m[i];
      return v;
   endfunction

   task automatic test_reset();
      logic [31:0] rd; int acks, starts;
      addr = ADDR_CTRL; we = 1'b1; data_in = 32'h1; str = 1'b1; cyc = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b0; #1;
      tests_run++; if (ack !== 1'b0) begin tests_failed++; $display("FAIL reset_ack: got %b want 0", ack); end
      tests_run++; if (data_out !== '0) begin tests_failed++; $display("FAIL reset_data: got %h want 0", data_out); end
      tests_run++; if (busy !== 1'b0 || core_start !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: busy %b start %b want 0 0", busy, core_start); end
      repeat (2) @(posedge clk); #1;
      tests_run++; if (ack !== 1'b0) begin tests_failed++; $display("FAIL reset_held_ack: got %b want 0", ack); end
      str = 1'b0; cyc = 1'b0; we = 1'b0; rst_n = 1'b1;
      busy_m = 1'b0;
      wb_xfer(ADDR_STATUS, 1'b0, '0, rd, acks, starts);
      tests_run++; if (rd !== 32'h0000_0014 || acks != 1) begin tests_failed++; $display("FAIL reset_status: got %h acks %0d want 00000014 acks 1", rd, acks); end
      tests_run++; if (wt_flat !== '0 || px_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_wt: wt %h px_valid %b want 0 0", wt_flat, px_valid); end
   endtask

   task automatic test_weights();
      logic [31:0] rd; int acks, starts, held, b2b, idle_nz; logic prev;
      logic [71:0] want;
      for (int i = 0; i < int'(WN); i++) begin
         wb_xfer(ADDR_WT_BASE + 8'(i), 1'b1, 32'(i + 1), rd, acks, starts);
         wt_m[i] = 8'(i + 1);
         tests_run++; if (acks != 1) begin tests_failed++; $display("FAIL wt_write_ack[%0d]: got %0d want 1", i, acks); end
      end
      want = 72'h09_0807_0605_0403_0201;
      tests_run++; if (wt_flat !== want) begin tests_failed++; $display("FAIL wt_flat: got %h want %h", wt_flat, want); end
      wb_xfer(8'h14, 1'b0, '0, rd, acks, starts);
      tests_run++; if (rd !== 32'h5 || acks != 1) begin tests_failed++; $display("FAIL wt_read: got %h acks %0d want 00000005 acks 1", rd, acks); end
      wb_xfer(8'h19, 1'b0, '0, rd, acks, starts);
      tests_run++; if (rd !== 32'h0 || acks != 1) begin tests_failed++; $display("FAIL wt_past_end: got %h acks %0d want 0 acks 1", rd, acks); end
      // Strobe held high: acks must alternate and data must be 0 between acks.
      addr = ADDR_STATUS; we = 1'b0; str = 1'b1; cyc = 1'b1;
      held = 0; b2b = 0; idle_nz = 0; prev = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (ack) held++;
         if (ack && prev) b2b++;
         if (!ack && data_out !== '0) idle_nz++;
         prev = ack;
      end
      str = 1'b0; cyc = 1'b0;
      @(posedge clk); #1;
      tests_run++; if (held != 3 || b2b != 0 || idle_nz != 0) begin tests_failed++; $display("FAIL ack_held: acks %0d b2b %0d idle_nz %0d want 3 0 0", held, b2b, idle_nz); end
   endtask

   task automatic test_in_fifo();
      logic [31:0] rd, want; int acks, starts, bad;
      for (int i = 0; i < 16; i++) begin
         wb_xfer(ADDR_DATA_IN, 1'b1, 32'hA0 + 32'(i), rd, acks, starts);
         in_q.push_back(32'hA0 + 32'(i));
      end
      wb_xfer(ADDR_DATA_IN, 1'b1, 32'hB0, rd, acks, starts);
      ovf_m = 1'b1;
      wb_xfer(ADDR_STATUS, 1'b0, '0, rd, acks, starts);
      tests_run++; if (rd !== 32'h0000_1032) begin tests_failed++; $display("FAIL in_full_status: got %h want 00001032", rd); end
      tests_run++; if (px_valid !== 1'b1 || px_data !== 32'hA0) begin tests_failed++; $display("FAIL in_head: valid %b data %h want 1 a0", px_valid, px_data); end
      wb_xfer(ADDR_CTRL, 1'b1, 32'h4, rd, acks, starts);
      ovf_m = 1'b0;
      // Push while full with a same-cycle pop is accepted.
      addr = ADDR_DATA_IN; we = 1'b1; data_in = 32'hC0; str = 1'b1; cyc = 1'b1; px_ready = 1'b1;
      @(posedge clk); #1;
      px_ready = 1'b0; str = 1'b0; cyc = 1'b0; we = 1'b0;
      tests_run++; if (ack !== 1'b1) begin tests_failed++; $display("FAIL in_simul_ack: got %b want 1", ack); end
      @(posedge clk); #1;
      void'(in_q.pop_front());
      in_q.push_back(32'hC0);
      wb_xfer(ADDR_STATUS, 1'b0, '0, rd, acks, starts);
      tests_run++; if (rd !== 32'h0000_1012) begin tests_failed++; $display("FAIL in_simul_status: got %h want 00001012", rd); end
      px_ready = 1'b1;
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         want = (i < 15) ? 32'hA1 + 32'(i) : 32'hC0;
         tests_run++; if (px_valid !== 1'b1 || px_data !== want) begin tests_failed++; $display("FAIL in_drain[%0d]: valid %b data %h want 1 %h", i, px_valid, px_data, want); end
         @(posedge clk); #1;
      end
      px_ready = 1'b0;
      in_q.delete();
      tests_run++; if (px_valid !== 1'b0) begin tests_failed++; $display("FAIL in_drained: px_valid %b want 0", px_valid); end
   endtask

   task automatic test_start_busy();
      logic [31:0] rd; int acks, starts; logic sc;
      wb_xfer(ADDR_CTRL, 1'b1, 32'h1, rd, acks, starts);
      busy_m = 1'b1;
      tests_run++; if (starts != 1 || busy !== 1'b1) begin tests_failed++; $display("FAIL start: pulses %0d busy %b want 1 1", starts, busy); end
      wb_xfer(ADDR_STATUS, 1'b0, '0, rd, acks, starts);
      tests_run++; if (rd !== 32'h0000_0015) begin tests_failed++; $display("FAIL start_status: got %h want 00000015", rd); end
      wb_xfer(ADDR_CTRL, 1'b1, 32'h1, rd, acks, starts);
      tests_run++; if (starts != 0 || busy !== 1'b1) begin tests_failed++; $display("FAIL start_while_busy: pulses %0d busy %b want 0 1", starts, busy); end
      core_done = 1'b1; @(posedge clk); #1; core_done = 1'b0;
      busy_m = 1'b0;
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL done: busy %b want 0", busy); end
      addr = ADDR_CTRL; we = 1'b1; data_in = 32'h1; str = 1'b1; cyc = 1'b1; core_done = 1'b1;
      @(posedge clk); #1;
      core_done = 1'b0; str = 1'b0; cyc = 1'b0; we = 1'b0;
      sc = core_start;
      @(posedge clk); #1;
      tests_run++; if (sc !== 1'b0 || core_start !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL done_and_start: start %b/%b busy %b want 0/0 0", sc, core_start, busy); end
   endtask

   task automatic test_out_fifo();
      logic [31:0] rd, want; int acks, starts;
      res_valid = 1'b1; res_data = 32'h11;
      tests_run++; if (res_ready !== 1'b1) begin tests_failed++; $display("FAIL out_ready: got %b want 1", res_ready); end
      @(posedge clk); #1; res_data = 32'h22;
      @(posedge clk); #1; res_valid = 1'b0;
      wb_xfer(ADDR_DATA_OUT, 1'b0, '0, rd, acks, starts);
      tests_run++; if (rd !== 32'h11) begin tests_failed++; $display("FAIL out_read0: got %h want 00000011", rd); end
      wb_xfer(ADDR_DATA_OUT, 1'b0, '0, rd, acks, starts);
      tests_run++; if (rd !== 32'h22) begin tests_failed++; $display("FAIL out_read1: got %h want 00000022", rd); end
      wb_xfer(ADDR_DATA_OUT, 1'b0, '0, rd, acks, starts);
      udf_m = 1'b1;
      tests_run++; if (rd !== 32'h0 || acks != 1) begin tests_failed++; $display("FAIL out_underflow_read: got %h acks %0d want 0 1", rd, acks); end
      wb_xfer(ADDR_STATUS, 1'b0, '0, rd, acks, starts);
      tests_run++; if (rd !== 32'h0000_0054) begin tests_failed++; $display("FAIL out_underflow_status: got %h want 00000054", rd); end
      for (int i = 0; i < 16; i++) begin
         res_valid = 1'b1; res_data = $urandom;
         out_q.push_back(res_data);
         @(posedge clk); #1;
      end
      res_valid = 1'b0;
      tests_run++; if (res_ready !== 1'b0) begin tests_failed++; $display("FAIL out_full_ready: got %b want 0", res_ready); end
      res_valid = 1'b1; res_data = 32'hDEAD;
      @(posedge clk); #1; res_valid = 1'b0;
      wb_xfer(ADDR_STATUS, 1'b0, '0, rd, acks, starts);
      tests_run++; if (rd !== 32'h0010_004C) begin tests_failed++; $display("FAIL out_full_status: got %h want 0010004c", rd); end
      wb_xfer(ADDR_DATA_OUT, 1'b0, '0, rd, acks, starts);
      want = out_q.pop_front();
      tests_run++; if (rd !== want || res_ready !== 1'b1) begin tests_failed++; $display("FAIL out_pop_full: got %h ready %b want %h 1", rd, res_ready, want); end
      // Same-cycle push and pop leave the count unchanged.
      addr = ADDR_DATA_OUT; we = 1'b0; str = 1'b1; cyc = 1'b1; res_valid = 1'b1; res_data = 32'hBEEF;
      @(posedge clk); #1;
      res_valid = 1'b0; str = 1'b0; cyc = 1'b0;
      want = out_q.pop_front();
      out_q.push_back(32'hBEEF);
      tests_run++; if (ack !== 1'b1 || data_out !== want) begin tests_failed++; $display("FAIL out_simul_read: ack %b data %h want 1 %h", ack, data_out, want); end
      @(posedge clk); #1;
      wb_xfer(ADDR_STATUS, 1'b0, '0, rd, acks, starts);
      tests_run++; if (rd !== exp_status()) begin tests_failed++; $display("FAIL out_simul_status: got %h want %h", rd, exp_status()); end
   endtask

   task automatic test_clear_unmapped();
      logic [31:0] rd; int acks, starts;
      wb_xfer(ADDR_DATA_IN, 1'b1, 32'h55, rd, acks, starts);
      wb_xfer(ADDR_DATA_IN, 1'b1, 32'h66, rd, acks, starts);
      wb_xfer(ADDR_CTRL, 1'b1, 32'h6, rd, acks, starts);
      in_q.delete(); out_q.delete(); ovf_m = 1'b0; udf_m = 1'b0;
      wb_xfer(ADDR_STATUS, 1'b0, '0, rd, acks, starts);
      tests_run++; if (rd !== 32'h0000_0014) begin tests_failed++; $display("FAIL clear_status: got %h want 00000014", rd); end
      tests_run++; if (px_valid !== 1'b0 || res_ready !== 1'b1) begin tests_failed++; $display("FAIL clear_stream: px_valid %b res_ready %b want 0 1", px_valid, res_ready); end
      wb_xfer(8'h7F, 1'b0, '0, rd, acks, starts);
      tests_run++; if (rd !== 32'h0 || acks != 1) begin tests_failed++; $display("FAIL unmapped_read: got %h acks %0d want 0 1", rd, acks); end
      wb_xfer(8'h7F, 1'b1, 32'hFFFF_FFFF, rd, acks, starts);
      wb_xfer(ADDR_STATUS, 1'b0, '0, rd, acks, starts);
      tests_run++; if (rd !== 32'h0000_0014 || wt_flat !== exp_wt()) begin tests_failed++; $display("FAIL unmapped_write: status %h wt %h want 00000014 %h", rd, wt_flat, exp_wt()); end
   endtask

   task automatic test_random();
      logic [31:0] rd, d, want; int acks, starts, op, idx; logic [2:0] bits; logic exp_start;
      for (int n = 0; n < 400; n++) begin
         op = int'($urandom_range(0, 10));
         if (op == 9) op = 0;
         if (op == 10) op = 3;
         case (op)
            0: begin
               d = $urandom;
               wb_xfer(ADDR_DATA_IN, 1'b1, d, rd, acks, starts);
               if (in_q.size() < DEPTH) in_q.push_back(d); else ovf_m = 1'b1;
               tests_run++; if (acks != 1) begin tests_failed++; $display("FAIL rnd_push_ack: got %0d want 1", acks); end
            end
            1: begin
               wb_xfer(ADDR_DATA_OUT, 1'b0, '0, rd, acks, starts);
               if (out_q.size() > 0) want = out_q.pop_front();
               else begin want = '0; udf_m = 1'b1; end
               tests_run++; if (rd !== want) begin tests_failed++; $display("FAIL rnd_pop: got %h want %h", rd, want); end
            end
            2: begin
               wb_xfer(ADDR_STATUS, 1'b0, '0, rd, acks, starts);
               tests_run++; if (rd !== exp_status()) begin tests_failed++; $display("FAIL rnd_status: got %h want %h", rd, exp_status()); end
            end
            3: begin
               tests_run++; if (res_ready !== (out_q.size() < DEPTH)) begin tests_failed++; $display("FAIL rnd_res_ready: got %b want %b", res_ready, out_q.size() < DEPTH); end
               res_valid = 1'b1; res_data = $urandom;
               if (out_q.size() < DEPTH) out_q.push_back(res_data);
               @(posedge clk); #1; res_valid = 1'b0;
            end
            4: begin
               want = (in_q.size() > 0) ? in_q[0] : px_data;
               tests_run++; if (px_valid !== (in_q.size() > 0) || px_data !== want) begin tests_failed++; $display("FAIL rnd_px: valid %b data %h want %b %h", px_valid, px_data, in_q.size() > 0, want); end
               px_ready = 1'b1;
               if (in_q.size() > 0) void'(in_q.pop_front());
               @(posedge clk); #1; px_ready = 1'b0;
            end
            5: begin
               idx = int'($urandom_range(0, WN - 1)); d = $urandom;
               wb_xfer(ADDR_WT_BASE + 8'(idx), 1'b1, d, rd, acks, starts);
               wt_m[idx] = d[7:0];
               tests_run++; if (wt_flat !== exp_wt()) begin tests_failed++; $display("FAIL rnd_wt_flat: got %h want %h", wt_flat, exp_wt()); end
            end
            6: begin
               idx = int'($urandom_range(0, WN));
               wb_xfer(ADDR_WT_BASE + 8'(idx), 1'b0, '0, rd, acks, starts);
               want = (idx < int'(WN)) ? 32'(wt_m[idx]) : 32'h0;
               tests_run++; if (rd !== want) begin tests_failed++; $display("FAIL rnd_wt_read[%0d]: got %h want %h", idx, rd, want); end
            end
            7: begin
               bits = 3'($urandom_range(0, 7));
               if ($urandom_range(0, 3) != 0) bits[1] = 1'b0;
               wb_xfer(ADDR_CTRL, 1'b1, 32'(bits), rd, acks, starts);
               exp_start = bits[0] && !busy_m;
               if (exp_start) busy_m = 1'b1;
               if (bits[1]) begin in_q.delete(); out_q.delete(); end
               if (bits[2]) begin ovf_m = 1'b0; udf_m = 1'b0; end
               tests_run++; if (starts != int'(exp_start) || busy !== busy_m) begin tests_failed++; $display("FAIL rnd_ctrl: pulses %0d busy %b want %0d %b", starts, busy, exp_start, busy_m); end
            end
            default: begin
               core_done = 1'b1; @(posedge clk); #1; core_done = 1'b0;
               busy_m = 1'b0;
               tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rnd_done: busy %b want 0", busy); end
            end
         endcase
      end
   endtask

   initial begin
      for (int i = 0; i < int'(WN); i++) wt_m[i] = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_weights();
      test_in_fifo();
      test_start_busy();
      test_out_fifo();
      test_clear_unmapped();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
